countdown_timer: RTL
====================

Name: countdown_timer

Overview:
BCD minutes:seconds down-counter for the timer function. Value range 00:00 to 59:59.
- Loaded with a preset; decrements once per 1 Hz enable tick while running.
- Flags expiry to the alarm/display logic.
- It is the decrementing counterpart of the 0-9 up-counting digit counters used for clock time, and feeds the same 4-bit-per-digit display path.

Parameters:
SEC_TENS_MAX, 5, maximum value of the seconds-tens digit
MIN_TENS_MAX, 5, maximum value of the minutes-tens digit
UNITS_MAX, 9, maximum value of any units digit

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-clk-wide 1 Hz enable pulse
load  input  1  capture preset digits (one clk)
preset_min_t  input  4  preset minutes tens (BCD)
preset_min_u  input  4  preset minutes units (BCD)
preset_sec_t  input  4  preset seconds tens (BCD)
preset_sec_u  input  4  preset seconds units (BCD)
start  input  1  begin or resume counting (pulse)
pause  input  1  halt counting (pulse)
ack  input  1  clear alarm (pulse)
min_t, min_u, sec_t, sec_u  output  4 each  current BCD digits
running  output  1  high in RUN state
done  output  1  one-clk pulse on reaching 00:00
alarm  output  1  level, high in DONE state until ack or load

Behaviour:
- Reset (async, active-high): all digits 0; state IDLE; running=0, done=0, alarm=0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Load:
  - Allowed in any state. Priority: load > pause > start > tick within the same cycle.
  - Digits are clamped on capture: units >9 become 9; tens >5 become 5.
  - Next state is IDLE; alarm clears.
- Start:
  - From IDLE or PAUSE, with value not 00:00: go to RUN.
  - With value 00:00: ignored, state unchanged.
  - Ignored in RUN and DONE.
- Pause: in RUN goes to PAUSE; ignored in other states.
- Tick in RUN: decrement the MM:SS value by one second on that clk edge.
  - sec_u 0 -> 9 with borrow into sec_t.
  - sec_t 0 -> 5 with borrow into min_u.
  - min_u 0 -> 9 with borrow into min_t.
  - Latency: 1 clk from tick to updated digits.
- Expiry: on the tick whose result is 00:00:
  - Same edge: state goes to DONE, done=1 for exactly one clk, alarm=1.
  - Digits stay at 00:00; no wrap to 59:59 ever.
- Tick outside RUN: ignored, digits hold.
- Ack: in DONE, clear alarm and go to IDLE (digits remain 00:00). Ignored elsewhere.
- Simultaneous events:
  - pause and tick in the same cycle in RUN: pause wins, no decrement.
  - load during RUN: the preset replaces the count and counting stops.
- Asserting reset mid-count: immediate return to the reset values; the preset is not retained.

Decomposition:
- Shared package (timer_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3;
  - digit max constants (9, 5);
  - BCD digit width 4.
- Sub-module bcd_down_digit, one instance per digit:
  - parameter MAX;
  - inputs clk, reset, load, load_val, dec_en;
  - outputs digit, is_zero;
  - wraps 0 -> MAX on dec_en; borrow = dec_en & is_zero.
- Top level holds the FSM, clamping, borrow chain and the 00:01 detect used for expiry.

Test Plan:
- Reset mid-run at 12:34 -> all digits 0, running=0, alarm=0 asynchronously, before the next clk edge.
- Load 00:03, start, 3 ticks -> digits 00:02, 00:01, 00:00. done pulses 1 clk on the third tick; alarm=1; state DONE. A further tick leaves 00:00.
- Load 10:00, start, 1 tick -> 09:59 (full borrow chain). Load 01:00, 1 tick -> 00:59.
- Load digits F,A,7,C -> captured as 5,9,5,9 (59:59); start with 00:00 loaded -> running stays 0.
- Load 00:10, start, 2 ticks, pause, 3 ticks, start, 1 tick:
  - -> 00:08 held through the pause, then 00:07;
  - pause+tick in the same cycle -> no decrement.
- In DONE assert ack -> alarm=0, IDLE. In DONE assert load 00:05 -> alarm=0, digits 00:05, IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding, digit width
// and the digit limits used by clamping and the borrow chain.
package timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] UNITS_MAX_C = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX_C  = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Out-of-range preset digits saturate to the digit maximum.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// Single BCD down-counting digit: loads a value, decrements on dec_en and
// wraps 0 -> MAX. The caller forms the borrow as dec_en & is_zero.
import timer_pkg::*;

module bcd_down_digit #(
  parameter logic [DIGIT_W-1:0] MAX = UNITS_MAX_C
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec_en,
  output logic [DIGIT_W-1:0] digit,
  output logic               is_zero
);

  assign is_zero = (digit == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec_en) begin
      digit <= is_zero ? MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with IDLE/RUN/PAUSE/DONE control, expiry pulse
// and a latched alarm level for the alarm/display path.
import timer_pkg::*;

module countdown_timer #(
  parameter int SEC_TENS_MAX = 5,
  parameter int MIN_TENS_MAX = 5,
  parameter int UNITS_MAX    = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               load,
  input  logic [DIGIT_W-1:0] preset_min_t,
  input  logic [DIGIT_W-1:0] preset_min_u,
  input  logic [DIGIT_W-1:0] preset_sec_t,
  input  logic [DIGIT_W-1:0] preset_sec_u,
  input  logic               start,
  input  logic               pause,
  input  logic               ack,
  output logic [DIGIT_W-1:0] min_t,
  output logic [DIGIT_W-1:0] min_u,
  output logic [DIGIT_W-1:0] sec_t,
  output logic [DIGIT_W-1:0] sec_u,
  output logic               running,
  output logic               done,
  output logic               alarm
);

  localparam logic [DIGIT_W-1:0] ST_MAXV = SEC_TENS_MAX[DIGIT_W-1:0];
  localparam logic [DIGIT_W-1:0] MT_MAXV = MIN_TENS_MAX[DIGIT_W-1:0];
  localparam logic [DIGIT_W-1:0] U_MAXV  = UNITS_MAX[DIGIT_W-1:0];

  state_t state_q, state_n;
  logic   done_n;
  logic   mt_z, mu_z, st_z, su_z;
  logic   val_zero, val_one;
  logic   dec_su, dec_st, dec_mu, dec_mt;

  assign val_zero = mt_z & mu_z & st_z & su_z;
  assign val_one  = mt_z & mu_z & st_z & (sec_u == 4'd1);

  // Load and pause both outrank a tick in the same cycle.
  assign dec_su = (state_q == ST_RUN) & tick & ~load & ~pause;
  assign dec_st = dec_su & su_z;
  assign dec_mu = dec_st & st_z;
  assign dec_mt = dec_mu & mu_z;

  bcd_down_digit #(.MAX(MT_MAXV)) u_min_t (
    .clk(clk), .reset(reset), .load(load),
    .load_val(clamp_digit(preset_min_t, MT_MAXV)),
    .dec_en(dec_mt), .digit(min_t), .is_zero(mt_z)
  );

  bcd_down_digit #(.MAX(U_MAXV)) u_min_u (
    .clk(clk), .reset(reset), .load(load),
    .load_val(clamp_digit(preset_min_u, U_MAXV)),
    .dec_en(dec_mu), .digit(min_u), .is_zero(mu_z)
  );

  bcd_down_digit #(.MAX(ST_MAXV)) u_sec_t (
    .clk(clk), .reset(reset), .load(load),
    .load_val(clamp_digit(preset_sec_t, ST_MAXV)),
    .dec_en(dec_st), .digit(sec_t), .is_zero(st_z)
  );

  bcd_down_digit #(.MAX(U_MAXV)) u_sec_u (
    .clk(clk), .reset(reset), .load(load),
    .load_val(clamp_digit(preset_sec_u, U_MAXV)),
    .dec_en(dec_su), .digit(sec_u), .is_zero(su_z)
  );

  always_comb begin
    state_n = state_q;
    done_n  = 1'b0;
    if (load) begin
      state_n = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: if (start && !val_zero) state_n = ST_RUN;
        ST_RUN: begin
          if (pause) begin
            state_n = ST_PAUSE;
          end else if (tick && val_one) begin
            // Digits reach 00:00 on this same edge, so no wrap is possible.
            state_n = ST_DONE;
            done_n  = 1'b1;
          end
        end
        ST_DONE: if (ack) state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_n;
      running <= (state_n == ST_RUN);
      done    <= done_n;
      alarm   <= (state_n == ST_DONE);
    end
  end

endmodule
